// File: rtl/bcd_counter_ndigit.sv
// bcd_counter_ndigit
//   N-digit synchronous BCD up/down counter. All digits share one clock;
//   the digit-to-digit carry is a combinational step enable, so every digit
//   that changes does so on the same edge.
//
// Parameters
//   DIGITS    number of BCD digits (1..8), digit 0 least significant
//   SATURATE  0: wrap 9..9 <-> 0..0, 1: hold at the limit and set sat_flag
//
// Ports
//   clock      system clock, rising edge
//   reset      asynchronous active-high reset
//   clear      synchronous clear to zero (highest synchronous priority)
//   load       synchronous parallel load of D (digits >9 clamp to 9)
//   enable     count enable
//   up         1 = count up, 0 = count down
//   D          packed BCD load value, digit i is D[4i+3:4i]
//   Q          packed BCD count, registered
//   carry_out  registered one-cycle pulse on wrap
//   at_limit   combinational: Q all-9s when up=1, all-0s when up=0
//   sat_flag   sticky flag, set when a count is blocked by saturation
module bcd_counter_ndigit #(
  parameter int unsigned DIGITS   = 4,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  load,
  input  logic                  enable,
  input  logic                  up,
  input  logic [4*DIGITS-1:0]   D,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  carry_out,
  output logic                  at_limit,
  output logic                  sat_flag
);

  function automatic logic [3:0] clamp9(input logic [3:0] v);
    return (v > 4'd9) ? 4'd9 : v;
  endfunction

  logic [4*DIGITS-1:0] q_step;   // value after one count step
  logic [4*DIGITS-1:0] d_clamp;  // load value with per-digit clamp
  logic [3:0]          cur;
  logic                run;      // all lower digits at their rollover value
  logic                wrap;     // every digit rolls over on this step
  logic                all9;
  logic                all0;

  // Step chain: digit i steps when all lower digits sit at 9 (up) or 0 (down).
  // Digits above 9 are treated as 9 both for stepping and for the chain.
  always_comb begin
    q_step  = '0;
    d_clamp = '0;
    cur     = '0;
    run     = 1'b1;
    all9    = 1'b1;
    all0    = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cur = clamp9(Q[4*i +: 4]);
      d_clamp[4*i +: 4] = clamp9(D[4*i +: 4]);
      if (run) begin
        if (up) q_step[4*i +: 4] = (cur == 4'd9) ? 4'd0 : cur + 4'd1;
        else    q_step[4*i +: 4] = (cur == 4'd0) ? 4'd9 : cur - 4'd1;
      end else begin
        q_step[4*i +: 4] = cur;
      end
      run  = run & (up ? (cur == 4'd9) : (cur == 4'd0));
      all9 = all9 & (Q[4*i +: 4] == 4'd9);
      all0 = all0 & (Q[4*i +: 4] == 4'd0);
    end
    wrap = run;
  end

  assign at_limit = up ? all9 : all0;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q         <= '0;
      carry_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (clear) begin
      Q         <= '0;
      carry_out <= 1'b0;
      sat_flag  <= 1'b0;
    end else if (load) begin
      Q         <= d_clamp;
      carry_out <= 1'b0;
    end else if (enable) begin
      if (SATURATE && wrap) begin
        carry_out <= 1'b0;
        sat_flag  <= 1'b1;
      end else begin
        Q         <= q_step;
        carry_out <= wrap;
      end
    end else begin
      carry_out <= 1'b0;
    end
  end

endmodule

// File: doc/bcd_counter_ndigit.md
Name: bcd_counter_ndigit

Overview:
- Parametrised N-digit synchronous BCD up/down counter with load, synchronous clear, wrap or saturate mode, and one-cycle carry/borrow pulse.
- Every digit is clocked from the single system clock. The digit-to-digit carry is a combinational enable, not a derived clock, so there is no ripple skew between digits.
- Drives display/timer datapaths in the lab designs. The packed BCD output feeds a seven-segment decoder downstream.

Parameters:
- DIGITS, 4, number of BCD digits (1..8); digit 0 is least significant.
- SATURATE, 0, 0 = wrap at 9..9/0..0; 1 = hold at the limit.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- clear  input  1  synchronous clear to zero.
- load  input  1  synchronous parallel load of D.
- enable  input  1  count enable.
- up  input  1  1 = count up, 0 = count down.
- D  input  4*DIGITS  packed BCD load value; digit i is D[4i+3:4i].
- Q  output  4*DIGITS  packed BCD count, registered.
- carry_out  output  1  registered one-cycle pulse on wrap (up past all-9s or down past all-0s).
- at_limit  output  1  combinational: Q is all-9s when up=1, or all-0s when up=0.
- sat_flag  output  1  sticky; set when a count is blocked by saturation; meaningful only when SATURATE=1.

Behaviour:
- Reset (async, immediate): Q=0, carry_out=0, sat_flag=0. Reset deassertion takes effect at the next rising edge.
- Priority at each rising edge: clear > load > enable count > hold.
- clear: Q=0, carry_out=0, sat_flag=0.
- load: Q=D. Any digit >9 is clamped to 9 per digit. carry_out=0. sat_flag unchanged.
- Count up: digit i steps when enable=1 and digits 0..i-1 are all 9. Digit 9 -> 0; otherwise +1.
- Count down: digit i steps when enable=1 and digits 0..i-1 are all 0. Digit 0 -> 9; otherwise -1.
- All stepping digits update on the same edge. No intermediate value is ever visible (e.g. 0199 -> 0200 directly).
- Wrap, SATURATE=0: all-9s up -> all-0s, and all-0s down -> all-9s. carry_out=1 in the same cycle Q shows the wrapped value, then 0 on the next edge unless wrapping again. DIGITS=1 at 9 with continuous up therefore pulses every 10 cycles.
- Limit, SATURATE=1: Q holds, carry_out stays 0, sat_flag<=1 (sticky until reset/clear).
- carry_out is 0 on any cycle without a wrap, including hold, load and clear.
- enable=0: Q holds. up is ignored.
- Direction change mid-count is legal and takes effect on the next enable edge.
- If Q holds a non-BCD value (cannot occur from legal inputs), the next count treats digits >9 as 9.
- Latency: one clock from sampled controls to Q/carry_out. at_limit is combinational from Q and up.

Test Plan:
- DIGITS=4, reset during count at Q=0357 -> Q=0000, carry_out=0 immediately, before the next edge; counting resumes 0001 after release with enable=1.
- Load 0198, enable, up -> Q sequence 0199, 0200, 0201; no cycle shows 0209 or 0100.
- Load 9998, up, enable for 3 cycles -> 9999, 0000 with carry_out=1 for exactly that cycle, then 0001 with carry_out=0. Load 0001, down, 3 cycles -> 0000, 9999 with carry_out=1, then 9998.
- load=1 with D=0xA3F2 -> Q=9392. Simultaneous clear=1, load=1, enable=1 -> Q=0000. load=1 with enable=1 -> Q=D, no count.
- SATURATE=1, Q=9999, up, enable 2 cycles -> Q stays 9999, carry_out=0, sat_flag=1. Then clear -> sat_flag=0.
- DIGITS=1 free-run up 25 cycles from 0 -> carry_out pulses at cycles 10 and 20 only; at_limit high when Q=9 with up=1.
